// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch sequencer.
//   NUM_SPR      number of sprite requesters (index 0 = highest priority)
//   ADDR_W       sprite ROM address width
//   TRANSPARENT  texel value treated as see-through
//   SPR_*        requester indices in priority order
//   fsm_state_t  sequencer state encoding
package sprite_pkg;

   localparam int          NUM_SPR     = 6;
   localparam int          ADDR_W      = 16;
   localparam logic [23:0] TRANSPARENT = 24'hFF00FF;

   localparam int SPR_MARIOD = 0;
   localparam int SPR_LUIGI  = 1;
   localparam int SPR_GOMBA  = 2;
   localparam int SPR_COIN1  = 3;
   localparam int SPR_COIN2  = 4;
   localparam int SPR_MARIO  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } fsm_state_t;

endpackage

// File: rtl/sprite_fetch_sequencer_prio_pick.sv
// Lowest-set-bit priority encoder.
//   req     request vector (bit 0 = highest priority)
//   idx     index of the lowest set bit (0 when req is empty)
//   onehot  one-hot mask of the lowest set bit (0 when req is empty)
module prio_pick #(
   parameter int N     = 6,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = req & (~req + N'(1));

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// Shares one synchronous sprite ROM read port among all sprites covering
// the current pixel. Probes hit sprites in priority order, skips
// transparent texels and reports the first opaque colour (or a miss).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pix_start  one-cycle strobe, spr_hit/spr_addr valid
//   spr_hit    per-sprite hit flags
//   spr_addr   flattened per-sprite ROM addresses, sprite i at [i*ADDR_W +: ADDR_W]
//   rom_rd     ROM read strobe
//   rom_addr   ROM address, valid while rom_rd=1 (0 otherwise)
//   rom_data   ROM texel, valid ROM_LAT cycles after rom_rd
//   pix_valid  one-cycle pulse, pix_hit/pix_rgb updated
//   pix_hit    opaque texel found
//   pix_rgb    opaque texel colour, 0 on a miss
//   busy       sequencer not idle
//   overrun    sticky, pix_start seen while busy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for pix_start; latches hit mask and addresses
// ISSUE    | one-cycle ROM read of the highest-priority pending sprite
// WAIT     | ROM_LAT-1 cycles of ROM latency (down-counter)
// CHECK    | inspect rom_data: opaque -> DONE, else next sprite or miss
// DONE     | publish result, pulse pix_valid next cycle
module sprite_fetch_sequencer #(
   parameter int          NUM_SPR     = sprite_pkg::NUM_SPR,
   parameter int          ADDR_W      = sprite_pkg::ADDR_W,
   parameter int          ROM_LAT     = 2,
   parameter logic [23:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pix_start,
   input  logic [NUM_SPR-1:0]        spr_hit,
   input  logic [NUM_SPR*ADDR_W-1:0] spr_addr,
   output logic                      rom_rd,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [23:0]               rom_data,
   output logic                      pix_valid,
   output logic                      pix_hit,
   output logic [23:0]               pix_rgb,
   output logic                      busy,
   output logic                      overrun
);

   import sprite_pkg::*;

   localparam int IDX_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
   localparam int CNT_W     = 2;
   localparam int WAIT_LOAD = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;

   fsm_state_t                state, state_nxt;
   logic [NUM_SPR-1:0]        pending;
   logic [NUM_SPR*ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]          wait_cnt;
   logic                      res_hit;
   logic [23:0]               res_rgb;

   logic [IDX_W-1:0]          pick_idx;
   logic [NUM_SPR-1:0]        pick_onehot;
   logic                      opaque;

   prio_pick #(
      .N     (NUM_SPR),
      .IDX_W (IDX_W)
   ) u_prio_pick (
      .req    (pending),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign opaque   = (rom_data != TRANSPARENT);
   assign busy     = (state != ST_IDLE);
   assign rom_rd   = (state == ST_ISSUE);
   assign rom_addr = rom_rd ? addr_q[pick_idx*ADDR_W +: ADDR_W] : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (pix_start) state_nxt = (spr_hit != '0) ? ST_ISSUE : ST_DONE;
         end
         ST_ISSUE: begin
            state_nxt = (ROM_LAT == 1) ? ST_CHECK : ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt == '0) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (opaque)               state_nxt = ST_DONE;
            else if (pending != '0)   state_nxt = ST_ISSUE;
            else                      state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pending   <= '0;
         addr_q    <= '0;
         wait_cnt  <= '0;
         res_hit   <= 1'b0;
         res_rgb   <= '0;
         pix_valid <= 1'b0;
         pix_hit   <= 1'b0;
         pix_rgb   <= '0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pix_valid <= (state == ST_DONE);
         if (pix_start && busy) overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (pix_start) begin
                  pending <= spr_hit;
                  addr_q  <= spr_addr;
                  res_hit <= 1'b0;
                  res_rgb <= '0;
               end
            end
            ST_ISSUE: begin
               pending  <= pending & ~pick_onehot;
               wait_cnt <= CNT_W'(WAIT_LOAD);
            end
            ST_WAIT: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
            end
            ST_CHECK: begin
               if (opaque) begin
                  res_hit <= 1'b1;
                  res_rgb <= rom_data;
               end
            end
            ST_DONE: begin
               pix_hit <= res_hit;
               pix_rgb <= res_rgb;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sprite_fetch_sequencer.md
# sprite_fetch_sequencer

Time-multiplexes one shared synchronous sprite ROM read port among all on-screen sprites for each VGA pixel. On every pixel strobe it captures the sprite hit vector and per-sprite ROM addresses, then probes the ROM in fixed priority order, skipping transparent texels. It returns the first opaque colour, or a miss so the colour mapper falls back to ground or black. It sits between the sprite position/hit logic and the colour mapper and replaces the per-sprite ROM read ports.

## Interface
Parameters:
- NUM_SPR, 6, number of sprite requesters; index 0 is highest priority (order: mariod, luigi, gomba, coin1, coin2, mario).
- ADDR_W, 16, sprite ROM address width.
- ROM_LAT, 2, ROM read latency in cycles from rom_rd to valid rom_data; legal range 1..4.
- TRANSPARENT, 24'hFF00FF, texel value treated as see-through.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  asynchronous, active-low reset.
- pix_start  in  1  one-cycle strobe; a new pixel's hit/address inputs are valid.
- spr_hit  in  NUM_SPR  per-sprite "pixel inside sprite box" flags.
- spr_addr  in  NUM_SPR*ADDR_W  flattened per-sprite ROM addresses; sprite i occupies [i*ADDR_W +: ADDR_W].
- rom_rd  out  1  read strobe to the shared ROM.
- rom_addr  out  ADDR_W  ROM address, valid while rom_rd=1.
- rom_data  in  24  ROM texel {R,G,B}.
- pix_valid  out  1  one-cycle pulse; the result is updated.
- pix_hit  out  1  an opaque sprite texel was found.
- pix_rgb  out  24  the opaque texel colour; 0 when pix_hit=0.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag; a pix_start arrived while busy.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: on pix_start, latch spr_hit into the pending mask and latch all spr_addr.
  - Pending mask nonzero: go to ISSUE.
  - Pending mask zero: go to DONE with pix_hit=0.
- ISSUE: select the lowest set pending bit k.
  - Drive rom_rd=1 and rom_addr=addr[k] for exactly one cycle.
  - Clear bit k and record k.
  - Go to WAIT, or straight to CHECK when ROM_LAT=1.
- WAIT: hold for ROM_LAT-1 cycles using a down-counter, then go to CHECK.
- CHECK: sample rom_data.
  - rom_data != TRANSPARENT: result = {hit=1, rgb=rom_data}; go to DONE.
  - Transparent and pending mask nonzero: go to ISSUE.
  - Transparent and pending mask empty: result = {0, 0}; go to DONE.
- DONE: update pix_hit/pix_rgb, pulse pix_valid, and go to IDLE.
  - pix_hit/pix_rgb hold between pulses.
- Lower-priority sprites are never probed once an opaque texel is found.
- spr_hit/spr_addr changes after the latch cycle have no effect.

## Timing
- Reset values: state IDLE, rom_rd=0, rom_addr=0, pix_valid=0, pix_hit=0, pix_rgb=0, busy=0, overrun=0, pending=0.
- Each probe costs ROM_LAT+1 cycles (ISSUE, WAIT×(ROM_LAT-1), CHECK).
- Latency from the pix_start cycle to the pix_valid cycle is 2 + p·(ROM_LAT+1), where p is the number of probes.
  - Zero hits: 2 cycles.
  - Worst case with defaults: 2 + 6·3 = 20 cycles.
  - The pixel period budget must exceed this plus 1.
- pix_start while busy (including the DONE cycle): ignored, and overrun is set the next cycle.
- pix_start on the first IDLE cycle after DONE is accepted.
- rom_rd is never high in two consecutive cycles.
- Reset asserted mid-operation: immediate return to reset values. An in-flight ROM return is ignored.

## Structure
- Package sprite_pkg holds:
  - NUM_SPR, ADDR_W, TRANSPARENT.
  - Sprite index constants: SPR_MARIOD=0, SPR_LUIGI=1, SPR_GOMBA=2, SPR_COIN1=3, SPR_COIN2=4, SPR_MARIO=5.
  - State enum fsm_state_t.
- Sub-module prio_pick: combinational lowest-set-bit encoder; outputs index and one-hot. It is instantiated once, on the pending mask.

## Test plan
- Reset, then pix_start with spr_hit=0 -> pix_valid exactly 2 cycles later, pix_hit=0, pix_rgb=0, no rom_rd.
- spr_hit=6'b000100, addr[2]=16'h0123, ROM returns 24'h8040C0 -> one rom_rd with rom_addr=16'h0123; pix_valid at cycle 5 with pix_hit=1, pix_rgb=24'h8040C0.
- spr_hit=6'b010011, sprite 0 texel = FF00FF, sprite 1 opaque 24'h112233 -> probes of 0 then 1 only; pix_valid at cycle 8 with rgb 24'h112233; sprite 4 never addressed.
- All 6 hit, all texels transparent -> 6 probes in order 0..5; pix_valid at cycle 20 with pix_hit=0, pix_rgb=0.
- Second pix_start at cycle 3 of a 6-probe pixel -> ignored, overrun=1 from cycle 4 and staying high; the first result is unaffected.
- Reset pulled low during WAIT -> next cycle: all outputs at reset values. A subsequent pix_start behaves as after a clean reset.
